sseg_mux_driver: RTL and testbench
==================================

// Module: sseg_mux_driver
// PURPOSE
//  Parametrised multiplexed seven-segment driver: NUM_BANKS displays of DIGITS_PER_BANK digits sharing
//  one digit-select sequence. Adds PWM brightness, anti-ghost dead time, per-digit blank/blink and
//  tear-free frame-boundary update via req/ack. Sits between game/score logic and the board pins.
// PARAMETERS
//  NUM_BANKS       2            number of displays (each own an/seg bus)
//  DIGITS_PER_BANK 4            digits per display (>=2)
//  CLK_HZ          100_000_000  clk frequency
//  DIGIT_HZ        1_000        digit-slot rate (slot = 1/DIGIT_HZ)
//  BRIGHT_W        4            brightness width; slot split into 2**BRIGHT_W sub-slots
//  BLINK_FRAMES    256          frames per blink half-period
//  localparam N = NUM_BANKS*DIGITS_PER_BANK; SUB_TICKS = CLK_HZ/(DIGIT_HZ*2**BRIGHT_W), must be >=1
// PORTS
//  clk          in  1          system clock
//  reset_n      in  1          async active-low reset
//  seg_in       in  N*7        digit d pattern at [d*7+:7], active-low {g..a}; d = bank*DIGITS_PER_BANK+idx
//  dp_in        in  N          decimal point per digit, active-high
//  blank_in     in  N          1 = digit dark
//  blink_in     in  N          1 = digit blinks
//  update_req   in  1          1-cycle strobe: capture seg_in/dp_in/blank_in/blink_in into pending
//  brightness   in  BRIGHT_W   0 = off, 2**BRIGHT_W-1 = max; sampled live (not shadowed)
//  update_ack   out 1          1-cycle pulse when pending set becomes active
//  frame_start  out 1          1-cycle pulse at start of digit 0
//  an           out N          anodes, active-low, bank b at [b*DIGITS_PER_BANK+:DIGITS_PER_BANK]
//  seg          out NUM_BANKS*8 bank b at [b*8+:8] = {dp_n, g..a}, active-low
// BEHAVIOUR
//  - Counters: sub_cnt 0..SUB_TICKS-1; pwm_phase 0..2**BRIGHT_W-1 advances on sub_cnt wrap;
//    digit_idx 0..DIGITS_PER_BANK-1 advances on pwm_phase wrap; wraps to 0 (frame boundary).
//  - Boundary cycle = digit_idx, pwm_phase, sub_cnt all at max. Next cycle frame_start=1.
//  - Anode drive: digit idx of every bank on iff 1 <= pwm_phase <= brightness (phase 0 = dead time,
//    all anodes off, blocks ghosting across digit change). brightness=0 -> never on.
//  - Digit visible iff anode on, active blank=0, and !(active blink=1 && blink_phase=1).
//    Invisible digit: anode stays high (off); seg = 8'hFF.
//  - Visible: seg[b] = {~dp, pattern} of active digit b*DIGITS_PER_BANK+digit_idx.
//  - blink_phase toggles every BLINK_FRAMES frames; counter frame-based, reset to phase 0 (shown).
//  - an/seg/frame_start/update_ack registered: 1-cycle latency from counter state.
//  - Shadowing: update_req copies inputs to pending, sets pending_valid; repeated req before
//    boundary overwrites (latest wins). At boundary, if pending_valid: active<=pending,
//    pending_valid<=0, update_ack=1 next cycle (aligned with frame_start).
//  - Simultaneous update_req on boundary cycle with pending_valid: old pending commits (ack),
//    new data becomes pending (pending_valid stays 1), commits next boundary.
//  - update_req on boundary cycle with no pending: captured, committed next boundary only.
//  - Reset (async, any time): counters 0, blink_phase 0, pending_valid 0, active blank all 1,
//    active seg all 1, dp/blink 0; an all 1, seg all 1, update_ack 0, frame_start 0.
//    Display dark until first commit. After release first slot is digit 0, dead-time phase.
//  - brightness changes take effect on next registered output cycle (no shadow).
// TESTING (CLK_HZ=64, DIGIT_HZ=4, BRIGHT_W=2 -> SUB_TICKS=4, slot 16 clk, frame 64 clk, BLINK_FRAMES=2)
//  1 reset_n=0 mid-frame -> an=all 1, seg=all 1 same cycle; release -> all dark, no ack,
//    frame_start every 64 clk.
//  2 brightness=3, update_req clk 10 (digit0 seg=7'h40, others blank) -> unchanged until boundary;
//    update_ack+frame_start one pulse at clk 64; then an[0]=0 for 12 of 16 clk per frame, seg=8'hC0.
//  3 brightness 1/2/0 -> an[0] low 4/8/0 clk per slot; low never during first 4 clk of slot.
//  4 blink_in[1]=1, dp_in[1]=1 -> digit1 visible frames 0-1, dark 2-3, repeat; seg[7]=0 when shown;
//    digit0 steady.
//  5 update_req A clk 20, B on boundary cycle -> ack at 64 shows A; B at next frame with second ack.
//  6 two update_req same frame (A then B) -> single ack, B shown, A never displayed.

Source files
------------

// File: rtl/sseg_mux_driver.sv
// Multiplexed seven-segment driver: NUM_BANKS displays share one digit scan, with PWM
// brightness, dead-time anti-ghosting, per-digit blank/blink and frame-aligned double buffering.

module sseg_bank_drv #(
  parameter int D     = 4,
  parameter int DIG_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIG_W-1:0] digit_idx,
  input  logic             anode_on,
  input  logic             blink_phase,
  input  logic [D*7-1:0]   seg_pat,
  input  logic [D-1:0]     dp,
  input  logic [D-1:0]     blank,
  input  logic [D-1:0]     blink,
  output logic [D-1:0]     an,
  output logic [7:0]       seg
);
  logic         vis;
  logic [6:0]   pat;
  logic [D-1:0] an_nxt;
  logic [7:0]   seg_nxt;

  always_comb begin
    pat     = seg_pat[int'(digit_idx)*7 +: 7];
    vis     = anode_on && !blank[digit_idx] && !(blink[digit_idx] && blink_phase);
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (vis) begin
      an_nxt[digit_idx] = 1'b0;
      seg_nxt           = {~dp[digit_idx], pat};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end
endmodule

module sseg_mux_driver #(
  parameter int NUM_BANKS       = 2,
  parameter int DIGITS_PER_BANK = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int DIGIT_HZ        = 1_000,
  parameter int BRIGHT_W        = 4,
  parameter int BLINK_FRAMES    = 256
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_BANKS*DIGITS_PER_BANK*7-1:0] seg_in,
  input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   dp_in,
  input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   blank_in,
  input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   blink_in,
  input  logic                                   update_req,
  input  logic [BRIGHT_W-1:0]                    brightness,
  output logic                                   update_ack,
  output logic                                   frame_start,
  output logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   an,
  output logic [NUM_BANKS*8-1:0]                 seg
);
  localparam int N         = NUM_BANKS*DIGITS_PER_BANK;
  localparam int D         = DIGITS_PER_BANK;
  localparam int SUB_TICKS = CLK_HZ/(DIGIT_HZ*(2**BRIGHT_W));
  localparam int SUB_W     = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
  localparam int DIG_W     = $clog2(D);
  localparam int BLK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SUB_W-1:0]    SUB_MAX = SUB_W'(SUB_TICKS-1);
  localparam logic [BRIGHT_W-1:0] PH_MAX  = '1;
  localparam logic [DIG_W-1:0]    DIG_MAX = DIG_W'(D-1);
  localparam logic [BLK_W-1:0]    BLK_MAX = BLK_W'(BLINK_FRAMES-1);

  typedef struct packed {
    logic [N*7-1:0] seg;
    logic [N-1:0]   dp;
    logic [N-1:0]   blank;
    logic [N-1:0]   blink;
  } digset_t;

  logic [SUB_W-1:0]    sub_cnt;
  logic [BRIGHT_W-1:0] pwm_phase;
  logic [DIG_W-1:0]    digit_idx;
  logic [BLK_W-1:0]    blk_cnt;
  logic                blink_phase;
  logic                boundary;
  logic                anode_on;
  digset_t             pend, act;
  logic                pend_vld;

  assign boundary = (sub_cnt == SUB_MAX) && (pwm_phase == PH_MAX) && (digit_idx == DIG_MAX);
  // Phase 0 of every slot is dead time so the previous digit's anode is off before the next turns on.
  assign anode_on = (pwm_phase != '0) && (pwm_phase <= brightness);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_cnt     <= '0;
      pwm_phase   <= '0;
      digit_idx   <= '0;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (sub_cnt == SUB_MAX) begin
        sub_cnt <= '0;
        if (pwm_phase == PH_MAX) begin
          pwm_phase <= '0;
          digit_idx <= (digit_idx == DIG_MAX) ? '0 : digit_idx + 1'b1;
        end else begin
          pwm_phase <= pwm_phase + 1'b1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
      if (boundary) begin
        if (blk_cnt == BLK_MAX) begin
          blk_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

  // Commit uses the pre-edge pending set; a req on the boundary cycle refills pending for next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act         <= '{seg: '1, dp: '0, blank: '1, blink: '0};
      pend        <= '0;
      pend_vld    <= 1'b0;
      update_ack  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (boundary && pend_vld) act <= pend;
      if (update_req) begin
        pend     <= '{seg: seg_in, dp: dp_in, blank: blank_in, blink: blink_in};
        pend_vld <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end
      update_ack  <= boundary && pend_vld;
      frame_start <= boundary;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sseg_bank_drv #(.D(D), .DIG_W(DIG_W)) u_bank (
      .clk         (clk),
      .reset_n     (reset_n),
      .digit_idx   (digit_idx),
      .anode_on    (anode_on),
      .blink_phase (blink_phase),
      .seg_pat     (act.seg[b*D*7 +: D*7]),
      .dp          (act.dp[b*D +: D]),
      .blank       (act.blank[b*D +: D]),
      .blink       (act.blink[b*D +: D]),
      .an          (an[b*D +: D]),
      .seg         (seg[b*8 +: 8])
    );
  end
endmodule

// File: tb/tb_sseg_mux_driver.sv
// Random + directed bench for sseg_mux_driver; expected outputs come from a frame-time model
// that derives digit/phase/blink purely from the cycle count since reset.

module tb_sseg_mux_driver;
  localparam int NB = 2, D = 4, N = NB*D, BW = 2, BLINK = 2;
  localparam int SUB = 4, SLOT = SUB*(1<<BW), FRAME = SLOT*D;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic [N*7-1:0]  seg_in = '0;
  logic [N-1:0]    dp_in = '0, blank_in = '0, blink_in = '0;
  logic            update_req = 1'b0;
  logic [BW-1:0]   brightness = '0;
  logic            update_ack, frame_start;
  logic [N-1:0]    an;
  logic [NB*8-1:0] seg;

  int tests = 0, fails = 0, k = 0;
  logic [N*7-1:0] m_seg, p_seg;
  logic [N-1:0]   m_dp, m_blank, m_blink, p_dp, p_blank, p_blink;
  bit             pv;

  sseg_mux_driver #(.NUM_BANKS(NB), .DIGITS_PER_BANK(D), .CLK_HZ(64), .DIGIT_HZ(4),
                    .BRIGHT_W(BW), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dp_in(dp_in), .blank_in(blank_in),
    .blink_in(blink_in), .update_req(update_req), .brightness(brightness),
    .update_ack(update_ack), .frame_start(frame_start), .an(an), .seg(seg));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s k=%0d obs=%h exp=%h", tag, k, obs, exp);
    end
  endtask

  task automatic mreset();
    k = 0; pv = 0;
    m_seg = '1; m_dp = '0; m_blank = '1; m_blink = '0;
    p_seg = '0; p_dp = '0; p_blank = '0; p_blink = '0;
  endtask

  // One clock: model the registered outputs from frame time k, then compare at the negedge.
  task automatic tick();
    int pos, dig, ph, bp, d;
    bit bnd, on, vis, efs, eack;
    logic [N-1:0]    ea;
    logic [NB*8-1:0] es;
    @(posedge clk);
    pos = k % FRAME; dig = pos / SLOT; ph = (pos % SLOT) / SUB; bp = (k / FRAME / BLINK) % 2;
    bnd = (pos == FRAME-1);
    on  = (ph >= 1) && (ph <= int'(brightness));
    ea = '1; es = '1;
    for (int b = 0; b < NB; b++) begin
      d = b*D + dig;
      vis = on && !m_blank[d] && !(m_blink[d] && bp == 1);
      if (vis) begin
        ea[d] = 1'b0;
        es[b*8 +: 8] = {~m_dp[d], m_seg[d*7 +: 7]};
      end
    end
    efs = bnd; eack = bnd && pv;
    if (bnd && pv) begin
      m_seg = p_seg; m_dp = p_dp; m_blank = p_blank; m_blink = p_blink; pv = 0;
    end
    if (update_req) begin
      p_seg = seg_in; p_dp = dp_in; p_blank = blank_in; p_blink = blink_in; pv = 1;
    end
    k++;
    @(negedge clk);
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("frame_start", frame_start, efs);
    chk("update_ack", update_ack, eack);
    update_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int m);
    while (k % FRAME != m) tick();
  endtask

  task automatic req_rand();
    seg_in   = 56'({$urandom(), $urandom()});
    dp_in    = 8'($urandom());
    blank_in = 8'($urandom() & $urandom());
    blink_in = 8'($urandom() & $urandom());
    update_req = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_an", an, {N{1'b1}});
    chk("rst_seg", seg, {NB*8{1'b1}});
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_ack", update_ack, 1'b0);
  endtask

  initial begin
    mreset();
    @(negedge clk); chk_reset();
    @(negedge clk); reset_n = 1'b1;
    // digit 0 shows 7'h40, everything else blank, full brightness
    brightness = 2'd3;
    run(10);
    seg_in = '0; seg_in[6:0] = 7'h40; dp_in = '0; blank_in = 8'hFE; blink_in = '0;
    update_req = 1'b1;
    run(200);
    // brightness sweep
    brightness = 2'd1; run_to(0); run(FRAME);
    brightness = 2'd2; run(FRAME);
    brightness = 2'd0; run(FRAME);
    brightness = 2'd3;
    // blinking digit 1 with dp
    seg_in[13:7] = 7'h79; dp_in = 8'h02; blank_in = 8'hFC; blink_in = 8'h02;
    update_req = 1'b1;
    run(5*FRAME);
    // A mid-frame, B on boundary cycle: two consecutive acks
    run_to(20); req_rand();
    run_to(FRAME-1); req_rand();
    run(150);
    // A then B in one frame: only B is shown
    run_to(5); req_rand();
    run_to(30); req_rand();
    run(100);
    // async reset mid-frame with a lit display
    run_to(37);
    reset_n = 1'b0;
    #1 chk_reset();
    @(negedge clk); chk_reset();
    @(negedge clk); reset_n = 1'b1;
    mreset();
    run(3*FRAME + 10);
    // random traffic, including requests on boundary cycles
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0 || (k % FRAME == FRAME-1 && $urandom_range(0, 3) == 0))
        req_rand();
      if ($urandom_range(0, 49) == 0) brightness = 2'($urandom());
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
